// File: rtl/rom_burst_rd.sv
// Burst-read ROM: one request streams LEN+1 consecutive (wrapping) words through a
// PIPE-stage read pipeline into a PIPE+1 deep valid/ready output buffer.
module rom_burst_rd #(
    parameter int unsigned                         DATA_W = 8,
    parameter int unsigned                         ADDR_W = 4,
    parameter logic [DATA_W*(2**ADDR_W)-1:0]       INIT   = '0,
    parameter int unsigned                         PIPE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CW    = 3;

    if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
        $error("rom_burst_rd: PIPE must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;

    logic [DATA_W-1:0] rom [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = INIT[g*DATA_W +: DATA_W];
    end

    // Read pipeline: stage 0 captures the ROM word on the issue edge.
    logic [PIPE-1:0]   pv;
    logic [PIPE-1:0]   pl;
    logic [DATA_W-1:0] pd [PIPE];

    // Skid buffer behind the output register; together they hold PIPE+1 words.
    logic [DATA_W-1:0] sk_d   [PIPE];
    logic [DATA_W-1:0] sk_d_n [PIPE];
    logic [PIPE-1:0]   sk_l, sk_l_n;
    logic [CW-1:0]     sk_cnt, sk_cnt_n;

    logic [CW-1:0] inflight_c;
    logic [CW-1:0] occupancy_c;
    logic          pop_c, out_free_c, in_v_c, sk_pop_c, sk_push_c, load_out_c, issue_c;

    assign pop_c       = rd_valid && rd_ready;
    assign out_free_c  = !rd_valid || rd_ready;
    assign in_v_c      = pv[PIPE-1];
    assign sk_pop_c    = out_free_c && (sk_cnt != '0);
    assign sk_push_c   = in_v_c && !(out_free_c && (sk_cnt == '0));
    assign load_out_c  = out_free_c && ((sk_cnt != '0) || in_v_c);

    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < PIPE; i++) begin
            inflight_c = inflight_c + CW'(pv[i]);
        end
    end

    // Credit: buffered + in flight - popped must stay below PIPE+1 before issuing.
    assign occupancy_c = CW'(rd_valid) + sk_cnt + inflight_c;
    assign issue_c     = (state == ISSUE) && (occupancy_c < (CW'(PIPE + 1) + CW'(pop_c)));

    always_comb begin
        sk_d_n   = sk_d;
        sk_l_n   = sk_l;
        sk_cnt_n = sk_cnt;
        if (sk_pop_c) begin
            for (int i = 0; i < PIPE - 1; i++) begin
                sk_d_n[i] = sk_d[i+1];
                sk_l_n[i] = sk_l[i+1];
            end
            sk_cnt_n = sk_cnt - CW'(1);
        end
        if (sk_push_c) begin
            for (int i = 0; i < PIPE; i++) begin
                if (CW'(i) == sk_cnt_n) begin
                    sk_d_n[i] = pd[PIPE-1];
                    sk_l_n[i] = pl[PIPE-1];
                end
            end
            sk_cnt_n = sk_cnt_n + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            pv        <= '0;
            pl        <= '0;
            pd        <= '{default: '0};
            sk_d      <= '{default: '0};
            sk_l      <= '0;
            sk_cnt    <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
        end else begin
            pv[0] <= issue_c;
            if (issue_c) begin
                pd[0] <= rom[addr];
                pl[0] <= (remaining == '0);
            end
            for (int i = 1; i < PIPE; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
                pl[i] <= pl[i-1];
            end

            sk_d   <= sk_d_n;
            sk_l   <= sk_l_n;
            sk_cnt <= sk_cnt_n;

            // Output register holds its word (and last value once empty) until reloaded.
            if (load_out_c) begin
                rd_valid <= 1'b1;
                rd_data  <= (sk_cnt != '0) ? sk_d[0] : pd[PIPE-1];
                rd_last  <= (sk_cnt != '0) ? sk_l[0] : pl[PIPE-1];
            end else if (pop_c) begin
                rd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= ISSUE;
                        addr      <= req_addr;
                        remaining <= req_len;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_c) begin
                        addr <= addr + ADDR_W'(1);
                        if (remaining == '0) begin
                            state <= DRAIN;
                        end else begin
                            remaining <= remaining - ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop_c && rd_last) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_rd.sv
// Bench for rom_burst_rd: a PIPE=1 and a PIPE=2 instance, each driven with directed and
// random bursts and checked every cycle against a queue model of the expected word stream.
`timescale 1ns/1ps
module tb_rom_burst_rd;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    function automatic logic [DATA_W*16-1:0] make_init();
        logic [DATA_W*16-1:0] v;
        for (int i = 0; i < 16; i++) v[i*DATA_W +: DATA_W] = 8'hA0 + 8'(i);
        return v;
    endfunction
    localparam logic [DATA_W*16-1:0] INIT_V = make_init();

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit done [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_run
        localparam int unsigned P = gi + 1;
        localparam logic [8:0] EXP_WRAP [4] = '{9'h0AE, 9'h0AF, 9'h0A0, 9'h1A1};

        logic              rst_n, req_valid, req_ready, rd_valid, rd_ready, rd_last, busy;
        logic [ADDR_W-1:0] req_addr, req_len;
        logic [DATA_W-1:0] rd_data;

        bit         m_busy, m_timed, prev_stall, prev_last;
        int         m_j, m_len, m_acc;
        logic [7:0] prev_data;
        logic [8:0] m_q   [$];
        logic [8:0] log_q [$];

        rom_burst_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT(INIT_V), .PIPE(P)) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
            .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
            .busy(busy)
        );

        // Model: checks the state left by the last edge, then predicts the coming edge.
        always @(negedge clk) begin
            bit         was_busy, exp_v;
            logic [8:0] exp_w;
            if (!rst_n) begin
                n_vec++;
                if (rd_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
                    rd_data !== 8'h00 || rd_last !== 1'b0) begin
                    n_err++;
                    $display("FAIL p%0d reset_state: valid=%b busy=%b req_ready=%b data=%h last=%b, required 0 0 1 00 0",
                             P, rd_valid, busy, req_ready, rd_data, rd_last);
                end
                m_q.delete();
                m_busy = 0; m_timed = 0; prev_stall = 0;
            end else begin
                if (m_busy) m_j++;
                n_vec++;
                if (busy !== m_busy || req_ready !== !m_busy) begin
                    n_err++;
                    $display("FAIL p%0d ctrl: busy=%b req_ready=%b, required busy=%b req_ready=%b",
                             P, busy, req_ready, m_busy, !m_busy);
                end
                if (!m_busy) begin
                    n_vec++;
                    if (rd_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL p%0d idle_valid: rd_valid=%b, required 0", P, rd_valid);
                    end
                end else if (m_timed) begin
                    exp_v = (m_j >= int'(P) + 1) && (m_j <= int'(P) + 1 + m_len);
                    n_vec++;
                    if (rd_valid !== exp_v) begin
                        n_err++;
                        $display("FAIL p%0d timing: edge E0+%0d rd_valid=%b, required %b", P, m_j, rd_valid, exp_v);
                    end
                end
                if (prev_stall) begin
                    n_vec++;
                    if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last) begin
                        n_err++;
                        $display("FAIL p%0d hold: valid=%b data=%h last=%b, required 1 %h %b",
                                 P, rd_valid, rd_data, rd_last, prev_data, prev_last);
                    end
                end
                if (m_busy && !rd_ready) m_timed = 0;

                was_busy = m_busy;
                if (rd_valid === 1'b1 && rd_ready) begin
                    n_vec++;
                    if (m_q.size() == 0) begin
                        n_err++;
                        $display("FAIL p%0d extra_word: data=%h last=%b, required no word", P, rd_data, rd_last);
                    end else begin
                        exp_w = m_q.pop_front();
                        if ({rd_last, rd_data} !== exp_w) begin
                            n_err++;
                            $display("FAIL p%0d word: last/data=%h, required %h", P, {rd_last, rd_data}, exp_w);
                        end
                        log_q.push_back({rd_last, rd_data});
                        if (exp_w[8]) m_busy = 0;
                    end
                end
                if (req_valid && !was_busy) begin
                    for (int k = 0; k <= int'(req_len); k++) begin
                        m_q.push_back({(k == int'(req_len)), 8'hA0 + 8'((int'(req_addr) + k) % 16)});
                    end
                    m_busy = 1; m_timed = 1; m_j = -1; m_len = int'(req_len); m_acc++;
                end
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
                prev_last  = rd_last;
            end
        end

        initial begin
            int a0;
            rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk); #1;

            // Single word
            log_q.delete();
            req_valid = 1'b1; req_addr = 4'd3; req_len = 4'd0;
            @(posedge clk); #1 req_valid = 1'b0;
            for (int t = 0; t < 200 && m_busy; t++) begin @(posedge clk); #1; end
            n_vec++;
            if (log_q.size() != 1 || log_q[0] !== 9'h1A3) begin
                n_err++;
                $display("FAIL p%0d single: %0d words first=%h, required 1 word 1a3",
                         P, log_q.size(), (log_q.size() != 0) ? log_q[0] : 9'h0);
            end

            // Wrap at the top address
            log_q.delete();
            req_valid = 1'b1; req_addr = 4'd14; req_len = 4'd3;
            @(posedge clk); #1 req_valid = 1'b0;
            for (int t = 0; t < 200 && m_busy; t++) begin @(posedge clk); #1; end
            n_vec++;
            if (log_q.size() != 4) begin
                n_err++;
                $display("FAIL p%0d wrap_count: %0d words, required 4", P, log_q.size());
            end
            for (int i = 0; i < 4 && i < log_q.size(); i++) begin
                n_vec++;
                if (log_q[i] !== EXP_WRAP[i]) begin
                    n_err++;
                    $display("FAIL p%0d wrap[%0d]: %h, required %h", P, i, log_q[i], EXP_WRAP[i]);
                end
            end

            // Full ROM burst
            log_q.delete();
            req_valid = 1'b1; req_addr = 4'd0; req_len = 4'd15;
            @(posedge clk); #1 req_valid = 1'b0;
            for (int t = 0; t < 200 && m_busy; t++) begin @(posedge clk); #1; end
            n_vec++;
            if (log_q.size() != 16 || log_q[0] !== 9'h0A0 || log_q[15] !== 9'h1AF) begin
                n_err++;
                $display("FAIL p%0d full: %0d words first=%h last=%h, required 16 words 0a0..1af",
                         P, log_q.size(), (log_q.size() != 0) ? log_q[0] : 9'h0,
                         (log_q.size() == 16) ? log_q[15] : 9'h0);
            end

            // Backpressure: stall five cycles while word 2 is presented
            log_q.delete();
            req_valid = 1'b1; req_addr = 4'd0; req_len = 4'd7;
            @(posedge clk); #1 req_valid = 1'b0;
            for (int t = 0; t < 200 && log_q.size() < 2; t++) begin @(posedge clk); #1; end
            rd_ready = 1'b0;
            repeat (5) begin
                @(posedge clk); #1;
                n_vec++;
                if (rd_valid !== 1'b1 || rd_data !== 8'hA2) begin
                    n_err++;
                    $display("FAIL p%0d stall: valid=%b data=%h, required 1 a2", P, rd_valid, rd_data);
                end
            end
            rd_ready = 1'b1;
            for (int t = 0; t < 200 && m_busy; t++) begin @(posedge clk); #1; end
            n_vec++;
            if (log_q.size() != 8) begin
                n_err++;
                $display("FAIL p%0d bp_count: %0d words, required 8", P, log_q.size());
            end
            for (int i = 0; i < 8 && i < log_q.size(); i++) begin
                n_vec++;
                if (log_q[i] !== {(i == 7), 8'hA0 + 8'(i)}) begin
                    n_err++;
                    $display("FAIL p%0d bp[%0d]: %h, required %h", P, i, log_q[i], {(i == 7), 8'hA0 + 8'(i)});
                end
            end

            // Request held high during a burst is only taken after the last word pops
            log_q.delete();
            a0 = m_acc;
            req_valid = 1'b1; req_addr = 4'd2; req_len = 4'd5;
            @(posedge clk); #1;
            req_addr = 4'd9; req_len = 4'd2;
            for (int t = 0; t < 200 && m_acc != a0 + 2; t++) begin @(posedge clk); #1; end
            req_valid = 1'b0;
            for (int t = 0; t < 200 && m_busy; t++) begin @(posedge clk); #1; end
            n_vec++;
            if (log_q.size() != 9 || log_q[5] !== 9'h1A7 || log_q[6] !== 9'h0A9 || log_q[8] !== 9'h1AB) begin
                n_err++;
                $display("FAIL p%0d busy_ignore: %0d words, required 9 ending 1a7 0a9 0aa 1ab", P, log_q.size());
            end

            // Reset in the middle of a full burst
            log_q.delete();
            req_valid = 1'b1; req_addr = 4'd0; req_len = 4'd15;
            @(posedge clk); #1 req_valid = 1'b0;
            for (int t = 0; t < 200 && log_q.size() < 4; t++) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            #1;
            n_vec++;
            if (rd_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL p%0d async_reset: valid=%b busy=%b req_ready=%b, required 0 0 1",
                         P, rd_valid, busy, req_ready);
            end
            @(posedge clk); #1 rst_n = 1'b1;
            @(posedge clk); #1;
            log_q.delete();
            req_valid = 1'b1; req_addr = 4'd5; req_len = 4'd2;
            @(posedge clk); #1 req_valid = 1'b0;
            for (int t = 0; t < 200 && m_busy; t++) begin @(posedge clk); #1; end
            n_vec++;
            if (log_q.size() != 3 || log_q[0] !== 9'h0A5 || log_q[2] !== 9'h1A7) begin
                n_err++;
                $display("FAIL p%0d after_reset: %0d words first=%h, required 3 words 0a5 0a6 1a7",
                         P, log_q.size(), (log_q.size() != 0) ? log_q[0] : 9'h0);
            end

            // Random requests and backpressure
            for (int c = 0; c < 800; c++) begin
                rd_ready  = ($urandom_range(0, 9) < ((c < 400) ? 9 : 6));
                req_valid = ($urandom_range(0, 3) == 0);
                req_addr  = ADDR_W'($urandom);
                req_len   = ADDR_W'($urandom);
                @(posedge clk); #1;
            end
            req_valid = 1'b0; rd_ready = 1'b1;
            for (int t = 0; t < 300 && m_busy; t++) begin @(posedge clk); #1; end
            n_vec++;
            if (m_busy || busy !== 1'b0) begin
                n_err++;
                $display("FAIL p%0d drain: model_busy=%b busy=%b, required 0 0", P, m_busy, busy);
            end
            done[gi] = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && !(done[0] && done[1]); t++) @(posedge clk);
        n_vec++;
        if (!(done[0] && done[1])) begin
            n_err++;
            $display("FAIL watchdog: done=%b%b, required 11", done[0], done[1]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
